mc_controller: RTL

Multi-cycle MIPS control unit: a parametrised successor to the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory ready handshake. It drives the shared-memory multi-cycle datapath: PC, IR, register file, ALU and unified memory. It adds `addu`, `subu`, `and`, `or`, `slt` and optional `j` to the existing `add`, `sub`, `ori`, `lw`, `sw`, `beq`.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_decode.sv | 44 ++++
 rtl/mc_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// mc_ctrl_pkg: shared states, opcode/funct values, ALUctr codes and instruction classes
// for the multi-cycle MIPS controller. Revision 1.0
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [3:0] {
    CL_NOP  = 4'd0,
    CL_ADD  = 4'd1,
    CL_ADDU = 4'd2,
    CL_SUB  = 4'd3,
    CL_SUBU = 4'd4,
    CL_AND  = 4'd5,
    CL_OR   = 4'd6,
    CL_SLT  = 4'd7,
    CL_ORI  = 4'd8,
    CL_LW   = 4'd9,
    CL_SW   = 4'd10,
    CL_BEQ  = 4'd11,
    CL_J    = 4'd12
  } iclass_e;

  function automatic logic is_rtype(input iclass_e c);
    return (c inside {CL_ADD, CL_ADDU, CL_SUB, CL_SUBU, CL_AND, CL_OR, CL_SLT});
  endfunction

  function automatic logic [2:0] alu_code(input iclass_e c);
    case (c)
      CL_SUB, CL_SUBU, CL_BEQ: return ALU_SUB;
      CL_OR, CL_ORI:           return ALU_OR;
      CL_AND:                  return ALU_AND;
      CL_SLT:                  return ALU_SLT;
      default:                 return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// mc_decode: combinational opcode/funct to instruction-class decoder with illegal flag.
// Revision 1.0
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_JUMP = 1'b1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o   = CL_NOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  class_o = CL_ADD;
          FN_ADDU: class_o = CL_ADDU;
          FN_SUB:  class_o = CL_SUB;
          FN_SUBU: class_o = CL_SUBU;
          FN_AND:  class_o = CL_AND;
          FN_OR:   class_o = CL_OR;
          FN_SLT:  class_o = CL_SLT;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ORI: class_o = CL_ORI;
      OP_LW:  class_o = CL_LW;
      OP_SW:  class_o = CL_SW;
      OP_BEQ: class_o = CL_BEQ;
      OP_J: begin
        if (EN_JUMP) class_o   = CL_J;
        else         illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// mc_controller: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory
// ready handshake. Revision 1.0
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTR_W = 3,
  parameter bit EN_JUMP  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic                IRWr,
  output logic                RegWr,
  output logic                MemRd,
  output logic                MemWr,
  output logic                IorD,
  output logic [1:0]          nPC_sel,
  output logic                RegDst,
  output logic                ExtOp,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                retire,
  output logic                illegal,
  output logic [2:0]          state
);

  state_e  state_q, state_d;
  iclass_e class_q;
  iclass_e dec_class;
  logic    dec_illegal;

  logic       pcwr_raw, irwr_raw, regwr_raw, memrd_raw, memwr_raw, iord_raw;
  logic [1:0] npc_raw;
  logic       regdst_raw, extop_raw, alusrc_raw, memtoreg_raw;
  logic [2:0] alu_raw;
  logic       retire_raw, illegal_raw;

  mc_decode #(.EN_JUMP(EN_JUMP)) u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .class_o   (dec_class),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      class_q <= CL_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) class_q <= dec_class;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcwr_raw     = 1'b0;
    irwr_raw     = 1'b0;
    regwr_raw    = 1'b0;
    memrd_raw    = 1'b0;
    memwr_raw    = 1'b0;
    iord_raw     = 1'b0;
    npc_raw      = 2'b00;
    regdst_raw   = 1'b0;
    extop_raw    = 1'b0;
    alusrc_raw   = 1'b0;
    memtoreg_raw = 1'b0;
    alu_raw      = ALU_ADD;
    retire_raw   = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memrd_raw = 1'b1;
        if (mem_ready) begin
          irwr_raw = 1'b1;
          pcwr_raw = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_raw = 1'b1;
          retire_raw  = 1'b1;
          state_d     = ST_FETCH;
        end else if (dec_class == CL_J) begin
          pcwr_raw   = 1'b1;
          npc_raw    = 2'b10;
          retire_raw = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_raw    = alu_code(class_q);
        alusrc_raw = class_q inside {CL_ORI, CL_LW, CL_SW};
        extop_raw  = class_q inside {CL_LW, CL_SW, CL_BEQ};
        if (class_q inside {CL_LW, CL_SW}) begin
          state_d = ST_MEM;
        end else if (class_q == CL_BEQ) begin
          pcwr_raw   = zero;
          npc_raw    = 2'b01;
          retire_raw = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        iord_raw  = 1'b1;
        memrd_raw = (class_q == CL_LW);
        memwr_raw = (class_q == CL_SW);
        if (mem_ready) begin
          if (class_q == CL_SW) begin
            retire_raw = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        regwr_raw    = 1'b1;
        regdst_raw   = is_rtype(class_q);
        memtoreg_raw = (class_q == CL_LW);
        retire_raw   = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are gated by rst_n directly so a reset edge kills any in-flight strobe at once.
  assign PCWr     = rst_n & pcwr_raw;
  assign IRWr     = rst_n & irwr_raw;
  assign RegWr    = rst_n & regwr_raw;
  assign MemRd    = rst_n & memrd_raw;
  assign MemWr    = rst_n & memwr_raw;
  assign IorD     = rst_n & iord_raw;
  assign nPC_sel  = rst_n ? npc_raw : 2'b00;
  assign RegDst   = rst_n & regdst_raw;
  assign ExtOp    = rst_n & extop_raw;
  assign ALUSrc   = rst_n & alusrc_raw;
  assign MemtoReg = rst_n & memtoreg_raw;
  assign ALUctr   = rst_n ? ALUCTR_W'(alu_raw) : '0;
  assign retire   = rst_n & retire_raw;
  assign illegal  = rst_n & illegal_raw;
  assign state    = rst_n ? state_q : 3'd0;

endmodule
`default_nettype wire
